// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared opcodes, FSM encoding and helpers for the EX-stage ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_SLL   = 5'b00010;
    localparam logic [4:0] ALU_SRL   = 5'b00011;
    localparam logic [4:0] ALU_SRA   = 5'b00100;
    localparam logic [4:0] ALU_AND   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_XOR   = 5'b00111;
    localparam logic [4:0] ALU_SLT   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_ADDI  = 5'b01010;
    localparam logic [4:0] ALU_SLLI  = 5'b01011;
    localparam logic [4:0] ALU_SRLI  = 5'b01100;
    localparam logic [4:0] ALU_SRAI  = 5'b01101;
    localparam logic [4:0] ALU_SLTI  = 5'b01110;
    localparam logic [4:0] ALU_SLTIU = 5'b01111;
    localparam logic [4:0] ALU_ANDI  = 5'b10000;
    localparam logic [4:0] ALU_XORI  = 5'b10001;
    localparam logic [4:0] ALU_ORI   = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

    function automatic logic is_shift(input logic [4:0] op);
        case (op)
            ALU_SLL, ALU_SLLI, ALU_SRL, ALU_SRLI, ALU_SRA, ALU_SRAI: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

    function automatic shift_kind_t shift_kind(input logic [4:0] op);
        case (op)
            ALU_SRL, ALU_SRLI: return SH_RL;
            ALU_SRA, ALU_SRAI: return SH_RA;
            default:           return SH_LL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_comb
//  Brief    : Single-cycle ALU operations and unsupported-opcode decode.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic w_lt_s;
    logic w_lt_u;

    assign w_lt_s = $signed(op_a) < $signed(op_b);
    assign w_lt_u = op_a < op_b;

    // Shift opcodes are legal here but their result comes from the iterative path.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_ADDI:   result = op_a + op_b;
            ALU_SUB:             result = op_a - op_b;
            ALU_AND, ALU_ANDI:   result = op_a & op_b;
            ALU_OR, ALU_ORI:     result = op_a | op_b;
            ALU_XOR, ALU_XORI:   result = op_a ^ op_b;
            ALU_SLT, ALU_SLTI:   result = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU, ALU_SLTIU: result = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_SLL, ALU_SLLI, ALU_SRL, ALU_SRLI,
            ALU_SRA, ALU_SRAI:   result = '0;
            default:             illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Brief    : EX-stage execution unit, valid/ready on both sides, 1 bit/cycle shifts.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    alu_state_t      r_state;
    shift_kind_t     r_kind;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    logic [XLEN-1:0] w_comb_result;
    logic            w_comb_illegal;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_acc_next;

    alu_comb #(
        .XLEN (XLEN)
    ) u_alu_comb (
        .alu_op  (alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (w_comb_result),
        .illegal (w_comb_illegal)
    );

    assign w_shamt = op_b[SHW-1:0];

    always_comb begin
        w_acc_next = r_acc;
        case (r_kind)
            SH_LL:   w_acc_next = {r_acc[XLEN-2:0], 1'b0};
            SH_RL:   w_acc_next = {1'b0, r_acc[XLEN-1:1]};
            SH_RA:   w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_kind    <= SH_LL;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_shift(alu_op)) begin
                            r_illegal <= 1'b0;
                            // A zero shift amount skips the iterative path entirely.
                            if (w_shamt == '0) begin
                                r_result <= op_a;
                                r_state  <= ST_DONE;
                            end else begin
                                r_acc   <= op_a;
                                r_cnt   <= w_shamt;
                                r_kind  <= shift_kind(alu_op);
                                r_state <= ST_SHIFT;
                            end
                        end else begin
                            r_result  <= w_comb_result;
                            r_illegal <= w_comb_illegal;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_acc_next;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign result    = r_result;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Brief    : Self-checking bench for alu_exec against a behavioural reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    int tests = 0;
    int fails = 0;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {illegal, result} straight from the opcode table.
    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        r  = 32'h0;
        case (op)
            5'd0, 5'd10:  r = a + b;
            5'd1:         r = a - b;
            5'd2, 5'd11:  r = a << sh;
            5'd3, 5'd12:  r = a >> sh;
            5'd4, 5'd13:  r = $signed(a) >>> sh;
            5'd5, 5'd16:  r = a & b;
            5'd6, 5'd18:  r = a | b;
            5'd7, 5'd17:  r = a ^ b;
            5'd8, 5'd14:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9, 5'd15:  r = (a < b) ? 32'd1 : 32'd0;
            default:      return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
        if (op inside {5'd2, 5'd3, 5'd4, 5'd11, 5'd12, 5'd13}) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Cycle-level view of the unit: idle, waiting out latency, or holding a result.
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_res   = 32'h0;
    bit          m_ill   = 1'b0;
    logic [31:0] p_res;
    bit          p_ill;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_wait  = 0;
            m_res   = 32'h0;
            m_ill   = 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                {p_ill, p_res} = ref_alu(alu_op, op_a, op_b);
                m_idle = 1'b0;
                m_wait = ref_lat(alu_op, op_b) - 1;
                if (m_wait == 0) begin
                    m_valid = 1'b1;
                    m_res   = p_res;
                    m_ill   = p_ill;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res   = p_res;
                m_ill   = p_ill;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", {31'h0, in_ready}, {31'h0, m_idle});
            check("busy", {31'h0, busy}, {31'h0, !m_idle});
            check("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            if (m_valid) begin
                check("result", result, m_res);
                check("illegal", {31'h0, illegal}, {31'h0, m_ill});
            end
        end
    end

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_ill, input int exp_lat,
                          input int hold);
        int k;
        int lat;
        @(negedge clk);
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 48) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("lit_result", result, exp_res);
        check("lit_illegal", {31'h0, illegal}, {31'h0, exp_ill});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'h0, out_valid}, 32'h1);
            check("stall_result", result, exp_res);
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ready_after_hs", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int seen;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 5'd0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_illegal", {31'h0, illegal}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Reset in the middle of a 20-bit shift.
        alu_op   = ALU_SLL;
        op_a     = 32'h1;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("no_stale_result", seen, 0);

        run_op(ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1,  0);
        run_op(ALU_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1,  0);
        run_op(ALU_SRAI, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32, 0);
        run_op(ALU_SRL,  32'h80000000, 32'd31,       32'h1,        1'b0, 32, 0);
        run_op(ALU_SLL,  32'h1,        32'h25,       32'h20,       1'b0, 6,  0);
        run_op(ALU_SLL,  32'h1234,     32'h0,        32'h1234,     1'b0, 1,  0);
        run_op(ALU_SRLI, 32'hABCD0000, 32'hFFFFFF00, 32'hABCD0000, 1'b0, 1,  0);
        run_op(ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1,  0);
        run_op(ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1,  0);
        run_op(ALU_SLTI, 32'd5,        32'd5,        32'h0,        1'b0, 1,  0);
        run_op(ALU_XOR,  32'hF0F0,     32'hFFFF,     32'h0F0F,     1'b0, 1,  10);
        run_op(5'b10111, 32'h1234,     32'h5678,     32'h0,        1'b1, 1,  0);
        run_op(ALU_ADDI, 32'd3,        32'd4,        32'd7,        1'b0, 1,  0);
        run_op(ALU_ORI,  32'hF000000F, 32'h00FF0000, 32'hF0FF000F, 1'b0, 1,  2);

        // Random traffic with random backpressure; the compare process does the checking.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            alu_op    = 5'($urandom_range(0, 31));
            op_a      = $urandom;
            op_b      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
